qmax_update_ctrl: RTL and testbench

//  Sequences read-compare-write updates of the per-state Q-max BRAM table (1-cycle registered read).

---
 rtl/qmax_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_qmax_update_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qmax_update_ctrl.sv
// qmax_update_ctrl: init sweep + round-robin read-compare-write of the Q-max table.
// Ports: i_valid/o_ready/i_addrN/i_qN requesters; o_mem_*/i_mem_data table; o_init_done, o_upd_* status.
module qmax_update_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter logic signed [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_valid,
  output logic [1:0]            o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_q0,
  input  logic [DATA_WIDTH-1:0] i_q1,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_r,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_w,
  output logic                  o_mem_read_en,
  output logic                  o_mem_write_en,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_init_done,
  output logic                  o_upd_done,
  output logic                  o_upd_id,
  output logic                  o_upd_changed
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_CMP
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   q_q, q_d;
  logic                    id_q, id_d;
  logic                    done_q, done_d;

  logic gnt_vld;
  logic gnt_id;
  logic gt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      addr_q  <= '0;
      q_q     <= '0;
      id_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      q_q     <= q_d;
      id_q    <= id_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    q_d     = q_q;
    id_d    = id_q;
    done_d  = done_q;

    o_ready        = 2'b00;
    o_mem_addr_r   = '0;
    o_mem_addr_w   = '0;
    o_mem_read_en  = 1'b0;
    o_mem_write_en = 1'b0;
    o_mem_data     = '0;
    o_upd_done     = 1'b0;
    o_upd_id       = 1'b0;
    o_upd_changed  = 1'b0;
    o_init_done    = done_q;

    // Pointer only matters on contention.
    gnt_vld = |i_valid;
    gnt_id  = (i_valid == 2'b11) ? rr_q
                                 : i_valid[1];
    gt = $signed(q_q) > $signed(i_mem_data);

    unique case (state_q)
      S_INIT: begin
        o_mem_write_en = 1'b1;
        o_mem_addr_w   = cnt_q;
        o_mem_data     = INIT_VALUE;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_IDLE: begin
        if (gnt_vld) begin
          o_ready = gnt_id ? 2'b10 : 2'b01;
          addr_d  = gnt_id ? i_addr1 : i_addr0;
          q_d     = gnt_id ? i_q1 : i_q0;
          id_d    = gnt_id;
          rr_d    = ~gnt_id;
          state_d = S_READ;
        end
      end
      S_READ: begin
        o_mem_read_en = 1'b1;
        o_mem_addr_r  = addr_q;
        state_d       = S_CMP;
      end
      S_CMP: begin
        o_upd_done = 1'b1;
        o_upd_id   = id_q;
        if (gt) begin
          o_mem_write_en = 1'b1;
          o_mem_addr_w   = addr_q;
          o_mem_data     = q_q;
          o_upd_changed  = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // State resets to INIT, whose write must not
    // leak out while reset is still held.
    if (!i_rst_n) begin
      o_ready        = 2'b00;
      o_mem_addr_r   = '0;
      o_mem_addr_w   = '0;
      o_mem_read_en  = 1'b0;
      o_mem_write_en = 1'b0;
      o_mem_data     = '0;
      o_upd_done     = 1'b0;
      o_upd_id       = 1'b0;
      o_upd_changed  = 1'b0;
      o_init_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_qmax_update_ctrl.sv
// tb_qmax_update_ctrl: scoreboard bench for qmax_update_ctrl.
// Table RAM modelled here; expected table traffic queued by stimulus.
module tb_qmax_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  valid = 2'b00;
  logic [1:0]  o_ready;
  logic [5:0]  addr0 = '0, addr1 = '0;
  logic [31:0] q0 = '0, q1 = '0;
  logic [5:0]  o_mem_addr_r, o_mem_addr_w;
  logic        o_mem_read_en, o_mem_write_en;
  logic [31:0] o_mem_data, i_mem_data;
  logic        o_init_done, o_upd_done;
  logic        o_upd_id, o_upd_changed;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  localparam int EV_RD = 0;
  localparam int EV_WR = 1;
  localparam int EV_DN = 2;

  typedef struct {
    int          typ;
    int          cyc;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        id;
    logic        chg;
  } ev_t;

  ev_t sbq[$];

  logic [31:0] mem [64];
  logic [31:0] rdata;

  qmax_update_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .o_ready        (o_ready),
    .i_addr0        (addr0),
    .i_addr1        (addr1),
    .i_q0           (q0),
    .i_q1           (q1),
    .o_mem_addr_r   (o_mem_addr_r),
    .o_mem_addr_w   (o_mem_addr_w),
    .o_mem_read_en  (o_mem_read_en),
    .o_mem_write_en (o_mem_write_en),
    .o_mem_data     (o_mem_data),
    .i_mem_data     (i_mem_data),
    .o_init_done    (o_init_done),
    .o_upd_done     (o_upd_done),
    .o_upd_id       (o_upd_id),
    .o_upd_changed  (o_upd_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign i_mem_data = rdata;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rdata = '0;
  end

  always @(posedge clk) begin
    if (o_mem_write_en) mem[o_mem_addr_w] <= o_mem_data;
    if (o_mem_read_en) rdata <= mem[o_mem_addr_r];
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int typ, input int c,
                      input logic [5:0] a,
                      input logic [31:0] d,
                      input logic id, input logic chg);
    ev_t e;
    e.typ = typ; e.cyc = c; e.addr = a;
    e.data = d; e.id = id; e.chg = chg;
    sbq.push_back(e);
  endtask

  task automatic sb_match(input int typ);
    ev_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_unexpected: event type %0d @cyc %0d, none expected",
               typ, cyc);
    end else begin
      e = sbq.pop_front();
      check("ev_type", 64'(typ), 64'(e.typ));
      check("ev_cycle", 64'(cyc), 64'(e.cyc));
      if (typ == EV_RD) begin
        check("rd_addr", 64'(o_mem_addr_r), 64'(e.addr));
      end else if (typ == EV_WR) begin
        check("wr_addr", 64'(o_mem_addr_w), 64'(e.addr));
        check("wr_data", 64'(o_mem_data), 64'(e.data));
      end else begin
        check("done_id", 64'(o_upd_id), 64'(e.id));
        check("done_chg", 64'(o_upd_changed), 64'(e.chg));
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("rw_excl", 64'(o_mem_read_en & o_mem_write_en), 64'd0);
      if (!o_upd_done)
        check("chg_idle", 64'(o_upd_changed), 64'd0);
      if (o_mem_read_en)  sb_match(EV_RD);
      if (o_mem_write_en) sb_match(EV_WR);
      if (o_upd_done)     sb_match(EV_DN);
    end
  end

  task automatic check_cleared(input string nm);
    check(nm, {o_ready, o_mem_read_en, o_mem_write_en,
               o_upd_done, o_upd_id, o_upd_changed, o_init_done,
               o_mem_addr_r, o_mem_addr_w, o_mem_data}, 64'd0);
  endtask

  // Enter with rst_n low; n < 64 aborts the sweep after n writes.
  task automatic sweep(input int n);
    int r;
    @(posedge clk); @(posedge clk); #1;
    check_cleared("rst_outputs");
    rst_n = 1'b1;
    r = cyc;
    for (int k = 0; k < n; k++)
      push(EV_WR, r + k, 6'(k), 32'd0, 1'b0, 1'b0);
    #1;
    check("init_busy", 64'({o_init_done, o_ready}), 64'd0);
    repeat (n) @(posedge clk);
    #1;
    if (n == 64) begin
      check("init_done", 64'(o_init_done), 64'd1);
    end else begin
      rst_n = 1'b0;
      #1;
      check_cleared("rst_mid_sweep");
    end
  endtask

  // Single-requester update, entered in IDLE at posedge+1.
  task automatic issue(input int id, input logic [5:0] a,
                       input logic [31:0] q, input logic chg);
    int t;
    if (id == 0) begin
      addr0 = a; q0 = q; valid = 2'b01;
    end else begin
      addr1 = a; q1 = q; valid = 2'b10;
    end
    #1;
    check("ready_single", 64'(o_ready), 64'(valid));
    t = cyc;
    push(EV_RD, t + 1, a, 32'd0, 1'b0, 1'b0);
    if (chg) push(EV_WR, t + 2, a, q, 1'b0, 1'b0);
    push(EV_DN, t + 2, 6'd0, 32'd0, 1'(id), chg);
    @(posedge clk); #1;
    valid = 2'b00;
    @(posedge clk); @(posedge clk); #1;
  endtask

  logic [1:0]  rr_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic        rr_chg  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n, last, t;
    sweep(64);

    // Contention: grants alternate, one accept per 3 cycles.
    addr0 = 6'd3; q0 = 32'd10;
    addr1 = 6'd4; q1 = 32'd20;
    valid = 2'b11;
    n = 0; last = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (o_ready != 2'b00) begin
        check("rr_grant", 64'(o_ready), 64'(rr_rdy[n]));
        if (n > 0)
          check("rr_spacing", 64'(cyc - last), 64'd3);
        last = cyc;
        t = cyc;
        push(EV_RD, t + 1, rr_rdy[n][1] ? 6'd4 : 6'd3,
             32'd0, 1'b0, 1'b0);
        if (rr_chg[n])
          push(EV_WR, t + 2, rr_rdy[n][1] ? 6'd4 : 6'd3,
               rr_rdy[n][1] ? 32'd20 : 32'd10, 1'b0, 1'b0);
        push(EV_DN, t + 2, 6'd0, 32'd0, rr_rdy[n][1], rr_chg[n]);
        n++;
      end
      @(posedge clk); #1;
    end
    if (n < 4) begin
      tests++; fails++;
      $display("FAIL rr_timeout: got %0d accepts expected 4", n);
    end
    valid = 2'b00;
    @(posedge clk); @(posedge clk); #1;

    issue(0, 6'd5, 32'd100, 1'b1);
    issue(1, 6'd5, -32'sd7, 1'b0);
    check("entry5_kept", 64'(mem[5]), 64'd100);
    issue(0, 6'd5, 32'd100, 1'b0);
    issue(1, 6'd9, 32'h7FFF_FFFF, 1'b1);
    issue(0, 6'd9, 32'h8000_0000, 1'b0);
    check("entry9_kept", 64'(mem[9]), 64'h7FFF_FFFF);

    // Reset while the update sits in READ.
    addr0 = 6'd7; q0 = 32'd55; valid = 2'b01;
    #1;
    t = cyc;
    push(EV_RD, t + 1, 6'd7, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    valid = 2'b00;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_cleared("rst_in_read");

    sweep(20);
    sweep(64);
    check("entry7_init", 64'(mem[7]), 64'd0);
    check("entry5_init", 64'(mem[5]), 64'd0);
    issue(1, 6'd7, 32'd1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
